// File: rtl/mips_pkg.sv
// ==========================================================================
// mips_pkg : shared widths, special register numbers and grant encoding
// Revision : 1.0
// ==========================================================================
`default_nettype none

package mips_pkg;

  localparam int ADDR_WIDTH   = 5;
  localparam int DATA_WIDTH   = 32;
  localparam int ZERO_REG     = 0;
  localparam int RESERVED_REG = 30;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ==========================================================================
// rr_arbiter2 : two-requester round-robin arbiter, combinational grants
// Revision    : 1.0
// ==========================================================================
`default_nettype none

module rr_arbiter2
  import mips_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_alu,
  input  logic req_mem,
  output logic gnt_alu,
  output logic gnt_mem
);

  grant_e last_grant;

  // On a tie the requester that did not win last time gets the port.
  assign gnt_alu = req_alu && (!req_mem || (last_grant == GNT_MEM));
  assign gnt_mem = req_mem && (!req_alu || (last_grant == GNT_ALU));

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= GNT_MEM;
    end else if (gnt_alu) begin
      last_grant <= GNT_ALU;
    end else if (gnt_mem) begin
      last_grant <= GNT_MEM;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ==========================================================================
// regfile_wb_arbiter : shares the RF write port between ALU and load
//                      writeback, with a busy scoreboard for RAW hazards
// Revision           : 1.0
// ==========================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = mips_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = mips_pkg::ADDR_WIDTH,
  parameter int RESERVED_REG = mips_pkg::RESERVED_REG
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_WIDTH-1:0]      alu_reg,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_WIDTH-1:0]      mem_reg,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_reg,
  output logic                       issue_ready,
  input  logic [ADDR_WIDTH-1:0]      readRegister1,
  input  logic [ADDR_WIDTH-1:0]      readRegister2,
  output logic                       hazard1,
  output logic                       hazard2,
  output logic                       RegWrite,
  output logic [ADDR_WIDTH-1:0]      writeRegister,
  output logic [DATA_WIDTH-1:0]      writeData,
  output logic                       dropped_write,
  output logic [2**ADDR_WIDTH-1:0]   busy
);

  import mips_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] R_ZERO = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] R_RSVD = ADDR_WIDTH'(RESERVED_REG);

  function automatic logic is_sink(input logic [ADDR_WIDTH-1:0] r);
    return (r == R_ZERO) || (r == R_RSVD);
  endfunction

  logic                    alu_gnt;
  logic                    mem_gnt;
  logic                    accept;
  logic                    acc_sink;
  logic [ADDR_WIDTH-1:0]   acc_reg;
  logic [DATA_WIDTH-1:0]   acc_data;
  logic                    issue_fire;
  logic [2**ADDR_WIDTH-1:0] busy_next;

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req_alu (alu_valid),
    .req_mem (mem_valid),
    .gnt_alu (alu_gnt),
    .gnt_mem (mem_gnt)
  );

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  assign accept   = alu_gnt || mem_gnt;
  assign acc_reg  = alu_gnt ? alu_reg  : mem_reg;
  assign acc_data = alu_gnt ? alu_data : mem_data;
  assign acc_sink = is_sink(acc_reg);

  // ------------------------------------------------------------------------
  // Write stage: one registered slot feeding the register file port.
  // Dropped writes complete the handshake but never raise RegWrite.
  // ------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      RegWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      dropped_write <= 1'b0;
    end else begin
      RegWrite      <= accept && !acc_sink;
      dropped_write <= accept && acc_sink;
      if (accept && !acc_sink) begin
        writeRegister <= acc_reg;
        writeData     <= acc_data;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Scoreboard: r0 and the reserved register are never tracked.
  // ------------------------------------------------------------------------
  assign issue_ready = !busy[issue_reg] || is_sink(issue_reg);
  assign issue_fire  = issue_valid && issue_ready && !is_sink(issue_reg);

  // Clear is applied before set so a same-edge issue keeps the bit.
  always_comb begin
    busy_next = busy;
    if (RegWrite) begin
      busy_next[writeRegister] = 1'b0;
    end
    if (issue_fire) begin
      busy_next[issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign hazard1 = busy[readRegister1] && (readRegister1 != R_ZERO);
  assign hazard2 = busy[readRegister2] && (readRegister2 != R_ZERO);

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ==========================================================================
// tb_regfile_wb_arbiter : directed scoreboard bench for regfile_wb_arbiter
// Revision              : 1.0
// ==========================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
  logic        alu_ready, mem_ready, issue_ready, hazard1, hazard2;
  logic [4:0]  alu_reg = '0, mem_reg = '0, issue_reg = '0;
  logic [4:0]  readRegister1 = '0, readRegister2 = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        RegWrite, dropped_write;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [31:0] busy;

  regfile_wb_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_reg       (alu_reg),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_reg       (mem_reg),
    .mem_data      (mem_data),
    .issue_valid   (issue_valid),
    .issue_reg     (issue_reg),
    .issue_ready   (issue_ready),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .hazard1       (hazard1),
    .hazard2       (hazard2),
    .RegWrite      (RegWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .dropped_write (dropped_write),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [36:0] exp_q[$];      // {reg, data} of writes that must appear
  logic [31:0] m_busy = '0;
  logic        m_last = 1'b1; // 1 = MEM granted last
  logic        m_wr_v = 1'b0;
  logic [4:0]  m_wr_r = '0;
  logic        m_drop = 1'b0;
  logic        m_ga, m_gm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sink(input logic [4:0] r);
    return (r == 5'd0) || (r == 5'd30);
  endfunction

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic tick();
    logic        iss_rdy;
    logic [31:0] nb;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic [36:0] e;
    #1;
    m_ga    = alu_valid && (!mem_valid || m_last);
    m_gm    = mem_valid && (!alu_valid || !m_last);
    iss_rdy = !m_busy[issue_reg] || sink(issue_reg);
    chk("alu_ready",   alu_ready,   m_ga);
    chk("mem_ready",   mem_ready,   m_gm);
    chk("issue_ready", issue_ready, iss_rdy);
    chk("hazard1",     hazard1,     m_busy[readRegister1] && readRegister1 != 0);
    chk("hazard2",     hazard2,     m_busy[readRegister2] && readRegister2 != 0);
    nb = m_busy;
    if (m_wr_v) nb[m_wr_r] = 1'b0;
    if (issue_valid && iss_rdy && !sink(issue_reg)) nb[issue_reg] = 1'b1;
    m_busy = nb;
    ar = m_ga ? alu_reg  : mem_reg;
    ad = m_ga ? alu_data : mem_data;
    m_wr_v = (m_ga || m_gm) && !sink(ar);
    m_drop = (m_ga || m_gm) && sink(ar);
    if (m_wr_v) begin
      m_wr_r = ar;
      exp_q.push_back({ar, ad});
    end
    if (m_ga) m_last = 1'b0;
    else if (m_gm) m_last = 1'b1;
    @(posedge clock);
    #1;
    chk("RegWrite",      RegWrite,      m_wr_v);
    chk("dropped_write", dropped_write, m_drop);
    chk("busy",          busy,          m_busy);
    if (RegWrite) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {writeRegister, writeData}, 37'h0);
      end else begin
        e = exp_q.pop_front();
        chk("writeRegister", writeRegister, e[36:32]);
        chk("writeData",     writeData,     e[31:0]);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset  = 1'b0;
    m_busy = '0;
    m_last = 1'b1;
    m_wr_v = 1'b0;
    m_drop = 1'b0;
    exp_q.delete();
    chk("rst_RegWrite",      RegWrite,      1'b0);
    chk("rst_writeRegister", writeRegister, 5'd0);
    chk("rst_writeData",     writeData,     32'd0);
    chk("rst_dropped",       dropped_write, 1'b0);
    chk("rst_busy",          busy,          32'd0);
  endtask

  initial begin
    do_reset();

    // Single ALU write to r5
    alu_valid = 1; alu_reg = 5'd5; alu_data = 32'h1234;
    tick();
    alu_valid = 0;
    tick();
    tick();

    // Sustained tie: grants alternate, ALU first after reset
    do_reset();
    alu_valid = 1; alu_reg = 5'd3; alu_data = 32'hA;
    mem_valid = 1; mem_reg = 5'd4; mem_data = 32'hB;
    chk("tie_first_is_alu", {m_last}, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("tie_alternation", {m_ga, m_gm}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    alu_valid = 0; mem_valid = 0;
    tick();
    tick();

    // Issue r7, blocked second issue, load writeback clears on commit edge
    issue_valid = 1; issue_reg = 5'd7; readRegister1 = 5'd7;
    tick();
    chk("busy7_set", busy[7], 1'b1);
    tick();                       // second issue to r7 sees issue_ready=0
    issue_valid = 0;
    mem_valid = 1; mem_reg = 5'd7; mem_data = 32'hCAFE_0007;
    tick();
    mem_valid = 0;
    tick();                       // RegWrite cycle: hazard1 still 1
    chk("hazard1_after_commit", hazard1, 1'b0);
    tick();

    // Write to idle r9, then re-issue r9 on the commit edge: set wins
    alu_valid = 1; alu_reg = 5'd9; alu_data = 32'h9999; readRegister2 = 5'd9;
    tick();
    alu_valid = 0;
    issue_valid = 1; issue_reg = 5'd9;
    tick();
    issue_valid = 0;
    chk("busy9_set_wins", busy[9], 1'b1);
    tick();

    // Dropped writes to r0 and r30; issue to r0 is always ready
    alu_valid = 1; alu_reg = 5'd0; alu_data = 32'hDEAD;
    issue_valid = 1; issue_reg = 5'd0;
    tick();
    alu_valid = 0; issue_valid = 0;
    mem_valid = 1; mem_reg = 5'd30; mem_data = 32'hBEEF;
    tick();
    mem_valid = 0;
    tick();

    // Accept a write, then reset before it commits
    alu_valid = 1; alu_reg = 5'd12; alu_data = 32'h0C0C;
    tick();
    alu_valid = 0;
    do_reset();
    alu_valid = 1; alu_reg = 5'd1; alu_data = 32'h11;
    mem_valid = 1; mem_reg = 5'd2; mem_data = 32'h22;
    tick();
    chk("post_reset_tie_alu", m_ga, 1'b1);
    alu_valid = 0;
    tick();                       // MEM now granted
    mem_valid = 0;
    tick();
    tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
